// File: rtl/mul_int_if.sv
// Handshake and operand bundle for the shift-add multiplier.
// MUL_INT_ADDEND_EN adds the addend operand c.
interface mul_int_if #(
  parameter int WIDTH = 4
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
`ifdef MUL_INT_ADDEND_EN
  logic [WIDTH-1:0]   c;
`endif
  logic               busy;
  logic               valid;
  logic               ovf;
  logic [2*WIDTH-1:0] p;

`ifdef MUL_INT_ADDEND_EN
  modport master (output start, a, b, c, input busy, valid, ovf, p);
  modport slave  (input start, a, b, c, output busy, valid, ovf, p);
`else
  modport master (output start, a, b, input busy, valid, ovf, p);
  modport slave  (input start, a, b, output busy, valid, ovf, p);
`endif
endinterface

// File: rtl/mul_int.sv
// Radix-2 shift-add unsigned multiplier, one multiplier bit per cycle, LSB first.
// Defining MUL_INT_ADDEND_EN preloads the accumulator with c, giving p = a*b + c.
module mul_int #(
  parameter int WIDTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  mul_int_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, next_state;

  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] sum;
  logic [2*WIDTH-1:0] preload;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] p_q;
  logic               valid_q;
  logic               ovf_q;
  logic               load;
  logic               step;
  logic               done;

`ifdef MUL_INT_ADDEND_EN
  assign preload = {{WIDTH{1'b0}}, bus.c};
`else
  assign preload = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A start always wins, even mid-run, so an abort is just a fresh load.
  always_comb begin
    next_state = state;
    load       = 1'b0;
    step       = 1'b0;
    done       = 1'b0;
    if (bus.start) begin
      next_state = RUN;
      load       = 1'b1;
    end else if (state == RUN) begin
      step = 1'b1;
      if (cnt == CW'(WIDTH - 1)) begin
        done       = 1'b1;
        next_state = IDLE;
      end
    end
  end

  assign sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      p_q     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      mcand   <= {{WIDTH{1'b0}}, bus.a};
      mplier  <= bus.b;
      acc     <= preload;
      cnt     <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (step) begin
      acc    <= sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + CW'(1);
      if (done) begin
        p_q     <= sum;
        valid_q <= 1'b1;
        ovf_q   <= |sum[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign bus.busy  = (state == RUN);
  assign bus.valid = valid_q;
  assign bus.ovf   = ovf_q;
  assign bus.p     = p_q;

endmodule

// File: tb/tb_mul_int.sv
// Randomized and directed bench for mul_int (WIDTH=4) against an arithmetic reference model.
// Honours MUL_INT_ADDEND_EN when defined.
module tb_mul_int;

  localparam int WIDTH = 4;
`ifdef MUL_INT_ADDEND_EN
  localparam bit ADDEND = 1'b1;
`else
  localparam bit ADDEND = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  mul_int_if #(.WIDTH(WIDTH)) bus ();

  mul_int #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference: a pending result plus the number of edges left until it appears.
  int   m_rem;
  int   m_pend;
  int   m_p;
  logic m_busy;
  logic m_valid;
  logic m_ovf;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".busy"},  32'(bus.busy),  32'(m_busy));
    checkOutput({tag, ".valid"}, 32'(bus.valid), 32'(m_valid));
    checkOutput({tag, ".ovf"},   32'(bus.ovf),   32'(m_ovf));
    checkOutput({tag, ".p"},     32'(bus.p),     32'(m_p));
  endtask

  task automatic modelReset();
    m_rem   = 0;
    m_pend  = 0;
    m_p     = 0;
    m_busy  = 1'b0;
    m_valid = 1'b0;
    m_ovf   = 1'b0;
  endtask

  task automatic modelEdge(input logic st, input int ia, input int ib, input int ic);
    if (st) begin
      m_pend  = ia * ib + (ADDEND ? ic : 0);
      m_rem   = WIDTH;
      m_busy  = 1'b1;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy  = 1'b0;
        m_valid = 1'b1;
        m_p     = m_pend;
        m_ovf   = (m_pend >= (1 << WIDTH));
      end
    end
  endtask

  task automatic applyStimulus(input logic st, input int ia, input int ib, input int ic);
    bus.start = st;
    bus.a     = WIDTH'(ia);
    bus.b     = WIDTH'(ib);
`ifdef MUL_INT_ADDEND_EN
    bus.c     = WIDTH'(ic);
`endif
    @(posedge clk);
    if (!rst) modelEdge(st, ia, ib, ic);
    #1;
    checkAll("cyc");
  endtask

  task automatic runIdle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15)));
  endtask

  initial begin
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
`ifdef MUL_INT_ADDEND_EN
    bus.c     = '0;
`endif
    modelReset();
    #1;
    checkAll("reset");
    applyStimulus(1'b1, 5, 5, 0);
    applyStimulus(1'b1, 5, 5, 0);
    rst = 1'b0;

    // 3*5
    applyStimulus(1'b1, 3, 5, 0);
    checkOutput("r031.busy", 32'(bus.busy), 32'd1);
    runIdle(3);
    checkOutput("r031.early", 32'(bus.valid), 32'd0);
    runIdle(1);
    checkOutput("r031.valid", 32'(bus.valid), 32'd1);
    checkOutput("r031.busy0", 32'(bus.busy), 32'd0);
    checkOutput("r031.p", 32'(bus.p), 32'h0F);
    checkOutput("r031.ovf", 32'(bus.ovf), 32'd0);

    // 13*11 overflows and holds through idle cycles with changing inputs
    applyStimulus(1'b1, 13, 11, 0);
    runIdle(4);
    checkOutput("r032.p", 32'(bus.p), 32'h8F);
    checkOutput("r032.ovf", 32'(bus.ovf), 32'd1);
    runIdle(10);
    checkOutput("r032.hold.p", 32'(bus.p), 32'h8F);
    checkOutput("r032.hold.valid", 32'(bus.valid), 32'd1);

    // zero operand, no early completion
    applyStimulus(1'b1, 0, 9, 0);
    runIdle(3);
    checkOutput("r033.early", 32'(bus.valid), 32'd0);
    runIdle(1);
    checkOutput("r033.valid", 32'(bus.valid), 32'd1);
    checkOutput("r033.p", 32'(bus.p), 32'h00);
    checkOutput("r033.ovf", 32'(bus.ovf), 32'd0);

    // abort by restart
    applyStimulus(1'b1, 7, 7, 0);
    runIdle(1);
    applyStimulus(1'b1, 2, 3, 0);
    runIdle(3);
    checkOutput("r034.novalid", 32'(bus.valid), 32'd0);
    runIdle(1);
    checkOutput("r034.valid", 32'(bus.valid), 32'd1);
    checkOutput("r034.p", 32'(bus.p), 32'd6);

    // asynchronous reset mid-run, start ignored while reset is high
    applyStimulus(1'b1, 9, 9, 0);
    runIdle(2);
    rst = 1'b1;
    #1;
    modelReset();
    checkOutput("r035.busy", 32'(bus.busy), 32'd0);
    checkOutput("r035.valid", 32'(bus.valid), 32'd0);
    checkOutput("r035.p", 32'(bus.p), 32'd0);
    applyStimulus(1'b1, 4, 4, 0);
    rst = 1'b0;
    runIdle(6);
    checkOutput("r035.idle", 32'(bus.valid), 32'd0);

    // start held high never completes
    for (int i = 0; i < 8; i++)
      applyStimulus(1'b1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 0);
    checkOutput("r023.novalid", 32'(bus.valid), 32'd0);
    checkOutput("r023.busy", 32'(bus.busy), 32'd1);
    runIdle(4);
    checkOutput("r023.done", 32'(bus.valid), 32'd1);

`ifdef MUL_INT_ADDEND_EN
    applyStimulus(1'b1, 15, 15, 15);
    runIdle(4);
    checkOutput("r036.p", 32'(bus.p), 32'hF0);
    checkOutput("r036.ovf", 32'(bus.ovf), 32'd1);
`endif

    // random traffic with occasional asynchronous resets
    for (int i = 0; i < 600; i++) begin
      int r;
      r = int'($urandom_range(0, 63));
      if (r == 0) begin
        rst = 1'b1;
        #1;
        modelReset();
        checkAll("rndrst");
        rst = 1'b0;
      end else begin
        applyStimulus(r < 10, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 15)));
      end
    end
    runIdle(WIDTH + 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
